// File: rtl/vend_sequencer.sv
// Vending-machine control FSM: accumulates coin credit, vends on select, then
// pays change (or a cancel refund) out one unit at a time, GAP cycles apart.
module vend_sequencer #(
  parameter int PRICE       = 5,
  parameter int VEND_CYCLES = 4,
  parameter int GAP         = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       coin1,
  input  logic       coin2,
  input  logic       coin5,
  input  logic       select,
  input  logic       cancel,
  output logic [3:0] credit,
  output logic [3:0] change,
  output logic       vend,
  output logic       change_pulse,
  output logic       coin_reject,
  output logic       busy
);

  localparam int VW = (VEND_CYCLES > 1) ? $clog2(VEND_CYCLES) : 1;
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [VW-1:0] VEND_LOAD = VW'(VEND_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LOAD  = GW'(GAP - 1);
  localparam logic [3:0]    PRICE_C   = 4'(PRICE);

  typedef enum logic [1:0] {IDLE, CREDIT, VEND, PAYOUT} state_t;

  state_t          state, state_n;
  logic [3:0]      credit_n, change_n;
  logic            vend_n, pulse_n, reject_n, busy_n;
  logic [VW-1:0]   vcnt, vcnt_n;
  logic [GW-1:0]   gcnt, gcnt_n;
  logic [1:0]      coin_cnt;
  logic [3:0]      coin_val;
  logic            any_coin;

  always_comb begin
    coin_cnt = {1'b0, coin1} + {1'b0, coin2} + {1'b0, coin5};
    any_coin = coin1 | coin2 | coin5;
    coin_val = 4'd0;
    if (coin1) coin_val = 4'd1;
    if (coin2) coin_val = 4'd2;
    if (coin5) coin_val = 4'd5;
  end

  always_comb begin
    state_n  = state;
    credit_n = credit;
    change_n = change;
    vend_n   = 1'b0;
    pulse_n  = 1'b0;
    reject_n = 1'b0;
    busy_n   = busy;
    vcnt_n   = vcnt;
    gcnt_n   = gcnt;
    case (state)
      IDLE, CREDIT: begin
        // cancel beats select beats coins; a coin beside a taken command is refused
        if (cancel && credit != 4'd0) begin
          change_n = credit;
          credit_n = 4'd0;
          busy_n   = 1'b1;
          gcnt_n   = GAP_LOAD;
          state_n  = PAYOUT;
          reject_n = any_coin;
        end else if (select && credit >= PRICE_C) begin
          change_n = credit - PRICE_C;
          credit_n = 4'd0;
          vend_n   = 1'b1;
          busy_n   = 1'b1;
          vcnt_n   = VEND_LOAD;
          state_n  = VEND;
          reject_n = any_coin;
        end else if (any_coin) begin
          if (coin_cnt == 2'd1 && credit < PRICE_C) begin
            credit_n = credit + coin_val;
            state_n  = CREDIT;
          end else begin
            reject_n = 1'b1;
          end
        end
      end
      VEND: begin
        reject_n = any_coin;
        if (vcnt == '0) begin
          gcnt_n  = GAP_LOAD;
          state_n = PAYOUT;
        end else begin
          vcnt_n = vcnt - 1'b1;
          vend_n = 1'b1;
        end
      end
      PAYOUT: begin
        reject_n = any_coin;
        if (change == 4'd0) begin
          busy_n  = 1'b0;
          state_n = IDLE;
        end else if (gcnt == '0) begin
          pulse_n  = 1'b1;
          change_n = change - 4'd1;
          gcnt_n   = GAP_LOAD;
        end else begin
          gcnt_n = gcnt - 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      credit       <= 4'd0;
      change       <= 4'd0;
      vend         <= 1'b0;
      change_pulse <= 1'b0;
      coin_reject  <= 1'b0;
      busy         <= 1'b0;
      vcnt         <= '0;
      gcnt         <= '0;
    end else begin
      state        <= state_n;
      credit       <= credit_n;
      change       <= change_n;
      vend         <= vend_n;
      change_pulse <= pulse_n;
      coin_reject  <= reject_n;
      busy         <= busy_n;
      vcnt         <= vcnt_n;
      gcnt         <= gcnt_n;
    end
  end

endmodule

// File: tb/tb_vend_sequencer.sv
// Directed bench for vend_sequencer (PRICE=5, VEND_CYCLES=4, GAP=3).
module tb_vend_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       coin1 = 1'b0, coin2 = 1'b0, coin5 = 1'b0, select = 1'b0, cancel = 1'b0;
  logic [3:0] credit, change;
  logic       vend, change_pulse, coin_reject, busy;

  int pass_cnt = 0;
  int total_cnt = 0;

  vend_sequencer #(.PRICE(5), .VEND_CYCLES(4), .GAP(3)) dut (
    .clk(clk), .reset(reset), .coin1(coin1), .coin2(coin2), .coin5(coin5),
    .select(select), .cancel(cancel), .credit(credit), .change(change),
    .vend(vend), .change_pulse(change_pulse), .coin_reject(coin_reject), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) cyc();
    total_cnt++;
    if ({credit, change, vend, change_pulse, coin_reject, busy} !== 12'h000)
      $display("FAIL reset_state got %h want 000", {credit, change, vend, change_pulse, coin_reject, busy});
    else pass_cnt++;
    reset = 1'b0;
    cyc();
  endtask

  // Sale at credit 7: vend 4 cycles, change 2 paid out at GAP spacing.
  task automatic test_sale_with_change();
    logic [6:0] exp;
    coin2 = 1'b1; cyc(); coin2 = 1'b0;
    total_cnt++;
    if (credit !== 4'd2) $display("FAIL t1_credit2 got %0d want 2", credit); else pass_cnt++;
    coin5 = 1'b1; cyc(); coin5 = 1'b0;
    total_cnt++;
    if (credit !== 4'd7 || coin_reject !== 1'b0)
      $display("FAIL t1_credit7 got %0d/%b want 7/0", credit, coin_reject);
    else pass_cnt++;
    select = 1'b1; cyc(); select = 1'b0;
    total_cnt++;
    if ({vend, busy, change, credit} !== {1'b1, 1'b1, 4'd2, 4'd0})
      $display("FAIL t1_select got %h want %h", {vend, busy, change, credit}, {1'b1, 1'b1, 4'd2, 4'd0});
    else pass_cnt++;
    for (int i = 1; i <= 11; i++) begin
      cyc();
      exp = {(i <= 3), (i == 7 || i == 10), (i < 11),
             (i < 7) ? 4'd2 : (i < 10) ? 4'd1 : 4'd0};
      total_cnt++;
      if ({vend, change_pulse, busy, change} !== exp)
        $display("FAIL t1_cycle%0d got %h want %h", i, {vend, change_pulse, busy, change}, exp);
      else pass_cnt++;
    end
  endtask

  task automatic test_exact_price();
    logic [6:0] exp;
    coin5 = 1'b1; cyc(); coin5 = 1'b0;
    select = 1'b1; cyc(); select = 1'b0;
    total_cnt++;
    if ({vend, busy, change} !== {1'b1, 1'b1, 4'd0})
      $display("FAIL t2_select got %h want %h", {vend, busy, change}, {1'b1, 1'b1, 4'd0});
    else pass_cnt++;
    for (int i = 1; i <= 6; i++) begin
      cyc();
      exp = {(i <= 3), 1'b0, (i < 5), 4'd0};
      total_cnt++;
      if ({vend, change_pulse, busy, change} !== exp)
        $display("FAIL t2_cycle%0d got %h want %h", i, {vend, change_pulse, busy, change}, exp);
      else pass_cnt++;
    end
  endtask

  task automatic test_cancel_refund();
    logic [6:0] exp;
    repeat (3) begin
      coin1 = 1'b1; cyc(); coin1 = 1'b0;
    end
    total_cnt++;
    if (credit !== 4'd3) $display("FAIL t3_credit3 got %0d want 3", credit); else pass_cnt++;
    cancel = 1'b1; cyc(); cancel = 1'b0;
    total_cnt++;
    if ({vend, busy, change, credit} !== {1'b0, 1'b1, 4'd3, 4'd0})
      $display("FAIL t3_cancel got %h want %h", {vend, busy, change, credit}, {1'b0, 1'b1, 4'd3, 4'd0});
    else pass_cnt++;
    for (int i = 1; i <= 10; i++) begin
      cyc();
      exp = {1'b0, (i % 3 == 0), (i < 10), 4'(3 - i / 3)};
      total_cnt++;
      if ({vend, change_pulse, busy, change} !== exp)
        $display("FAIL t3_cycle%0d got %h want %h", i, {vend, change_pulse, busy, change}, exp);
      else pass_cnt++;
    end
  endtask

  task automatic test_rejects();
    int n;
    coin1 = 1'b1; coin2 = 1'b1; cyc(); coin1 = 1'b0; coin2 = 1'b0;
    total_cnt++;
    if (coin_reject !== 1'b1 || credit !== 4'd0)
      $display("FAIL t4_double_coin got %b/%0d want 1/0", coin_reject, credit);
    else pass_cnt++;
    cyc();
    total_cnt++;
    if (coin_reject !== 1'b0) $display("FAIL t4_reject_width got %b want 0", coin_reject); else pass_cnt++;
    coin5 = 1'b1; cyc(); coin5 = 1'b0;
    coin2 = 1'b1; cyc(); coin2 = 1'b0;
    total_cnt++;
    if (coin_reject !== 1'b1 || credit !== 4'd5)
      $display("FAIL t4_coin_at_price got %b/%0d want 1/5", coin_reject, credit);
    else pass_cnt++;
    cancel = 1'b1; cyc(); cancel = 1'b0;
    n = 0;
    while (busy && n < 100) begin cyc(); n++; end
    total_cnt++;
    if (busy !== 1'b0 || credit !== 4'd0)
      $display("FAIL t4_refund_done got busy=%b credit=%0d want 0/0", busy, credit);
    else pass_cnt++;
    coin1 = 1'b1; cyc(); coin1 = 1'b0;
    coin2 = 1'b1; cyc(); coin2 = 1'b0;
    select = 1'b1; cyc(); select = 1'b0;
    total_cnt++;
    if ({vend, busy, credit, change} !== {1'b0, 1'b0, 4'd3, 4'd0})
      $display("FAIL t4_select_low got %h want %h", {vend, busy, credit, change}, {1'b0, 1'b0, 4'd3, 4'd0});
    else pass_cnt++;
    cancel = 1'b1; cyc(); cancel = 1'b0;
    n = 0;
    while (busy && n < 100) begin cyc(); n++; end
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL t4_cleanup got busy=%b want 0", busy); else pass_cnt++;
  endtask

  task automatic test_cancel_priority();
    logic [6:0] exp;
    coin1 = 1'b1; cyc(); coin1 = 1'b0;
    coin5 = 1'b1; cyc(); coin5 = 1'b0;
    total_cnt++;
    if (credit !== 4'd6) $display("FAIL t5_credit6 got %0d want 6", credit); else pass_cnt++;
    cancel = 1'b1; select = 1'b1; cyc(); cancel = 1'b0; select = 1'b0;
    total_cnt++;
    if ({vend, busy, change, credit} !== {1'b0, 1'b1, 4'd6, 4'd0})
      $display("FAIL t5_cancel got %h want %h", {vend, busy, change, credit}, {1'b0, 1'b1, 4'd6, 4'd0});
    else pass_cnt++;
    for (int i = 1; i <= 19; i++) begin
      if (i == 1) coin5 = 1'b1;
      cyc();
      coin5 = 1'b0;
      total_cnt++;
      if (coin_reject !== (i == 1))
        $display("FAIL t5_reject%0d got %b want %b", i, coin_reject, (i == 1));
      else pass_cnt++;
      exp = {1'b0, (i % 3 == 0), (i < 19), 4'(6 - i / 3)};
      total_cnt++;
      if ({vend, change_pulse, busy, change} !== exp)
        $display("FAIL t5_cycle%0d got %h want %h", i, {vend, change_pulse, busy, change}, exp);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid_payout();
    coin2 = 1'b1; cyc(); coin2 = 1'b0;
    coin5 = 1'b1; cyc(); coin5 = 1'b0;
    select = 1'b1; cyc(); select = 1'b0;
    repeat (5) cyc();
    total_cnt++;
    if ({busy, vend, change} !== {1'b1, 1'b0, 4'd2})
      $display("FAIL t6_in_payout got %h want %h", {busy, vend, change}, {1'b1, 1'b0, 4'd2});
    else pass_cnt++;
    #2 reset = 1'b1;
    #1;
    total_cnt++;
    if ({credit, change, vend, change_pulse, coin_reject, busy} !== 12'h000)
      $display("FAIL t6_async_reset got %h want 000", {credit, change, vend, change_pulse, coin_reject, busy});
    else pass_cnt++;
    #1 reset = 1'b0;
    cyc();
    coin2 = 1'b1; cyc(); coin2 = 1'b0;
    total_cnt++;
    if ({credit, coin_reject, busy} !== {4'd2, 1'b0, 1'b0})
      $display("FAIL t6_after_reset got %h want %h", {credit, coin_reject, busy}, {4'd2, 1'b0, 1'b0});
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_sale_with_change();
    test_exact_price();
    test_cancel_refund();
    test_rejects();
    test_cancel_priority();
    test_reset_mid_payout();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
